// File: rtl/dm_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dm_arbiter_pkg
// Shared definitions for the data-memory arbitration path. Also used by the
// AHB control block and the CPU memory interface.
//   DM_ADDR_W : word address width of the data memory (2048 words)
//   DATA_W    : data memory word width
//   req_id_e  : requester identifiers (REQ_CPU / REQ_AHB)
// -----------------------------------------------------------------------------
package dm_arbiter_pkg;

    localparam int DM_ADDR_W = 11;
    localparam int DATA_W    = 32;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_AHB = 1'b1
    } req_id_e;

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// dm_arb_starve_cnt
// Saturating counter of consecutive cycles in which a low-priority requester
// was pending but not granted. Raises prio once the count reaches LIMIT.
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   req  : low-priority request pending
//   gnt  : low-priority request granted this cycle
//   prio : low-priority requester must win the next arbitration
// -----------------------------------------------------------------------------
module dm_arb_starve_cnt #(
    parameter int LIMIT = 4,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic req,
    input  logic gnt,
    output logic prio
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (req && !gnt) begin
            if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            // granted, or request withdrawn: the starvation episode is over
            cnt <= '0;
        end
    end

    assign prio = (cnt >= CNT_W'(LIMIT));

endmodule

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Shares the single-port data memory (synchronous read, 1-cycle latency)
// between the CPU load/store port and the AHB host port. CPU has fixed
// priority; an AHB request that loses STARVE_LIMIT consecutive cycles wins the
// next one. Read data is tagged with its issuer and returned one cycle later.
//   clk, rstn                      : clock, asynchronous active-low reset
//   cpu_en                         : CPU out of reset; gates CPU requests
//   cpu_req/we/addr/wdata          : CPU access request
//   cpu_gnt, cpu_rvalid, cpu_rdata : CPU grant and read return
//   ahb_req/we/addr/wdata          : host access request
//   ahb_gnt, ahb_rvalid, ahb_rdata : host grant and read return
//   mem_addr/din/wen, mem_dout     : data memory port
// -----------------------------------------------------------------------------
module dm_arbiter #(
    parameter int ADDR_W       = dm_arbiter_pkg::DM_ADDR_W,
    parameter int DATA_W       = dm_arbiter_pkg::DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cpu_en,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ahb_req,
    input  logic              ahb_we,
    input  logic [ADDR_W-1:0] ahb_addr,
    input  logic [DATA_W-1:0] ahb_wdata,
    output logic              ahb_gnt,
    output logic              ahb_rvalid,
    output logic [DATA_W-1:0] ahb_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wen,
    input  logic [DATA_W-1:0] mem_dout
);

    import dm_arbiter_pkg::*;

    logic    creq;
    logic    ahb_prio;
    logic    rd_pend;
    req_id_e rd_owner;

    // Grants are qualified with rstn so nothing reaches the memory while
    // the block is held in reset.
    assign creq    = cpu_req & cpu_en & rstn;
    assign cpu_gnt = creq & ~(ahb_req & ahb_prio);
    assign ahb_gnt = ahb_req & rstn & ~cpu_gnt;

    dm_arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (4)
    ) u_starve (
        .clk  (clk),
        .rstn (rstn),
        .req  (ahb_req),
        .gnt  (ahb_gnt),
        .prio (ahb_prio)
    );

    always_comb begin
        mem_addr = cpu_addr;
        mem_din  = cpu_wdata;
        mem_wen  = 1'b0;
        if (cpu_gnt) begin
            mem_wen = cpu_we;
        end else if (ahb_gnt) begin
            mem_addr = ahb_addr;
            mem_din  = ahb_wdata;
            mem_wen  = ahb_we;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_pend  <= 1'b0;
            rd_owner <= REQ_CPU;
        end else begin
            rd_pend <= (cpu_gnt & ~cpu_we) | (ahb_gnt & ~ahb_we);
            if (cpu_gnt && !cpu_we) begin
                rd_owner <= REQ_CPU;
            end else if (ahb_gnt && !ahb_we) begin
                rd_owner <= REQ_AHB;
            end
        end
    end

    // Decoded from the registered tag so a reset drops rvalid immediately.
    assign cpu_rvalid = rd_pend & (rd_owner == REQ_CPU);
    assign ahb_rvalid = rd_pend & (rd_owner == REQ_AHB);
    assign cpu_rdata  = mem_dout;
    assign ahb_rdata  = mem_dout;

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
// Directed bench for dm_arbiter with a behavioural 2048 x 32 synchronous-read
// data memory. Memory is preloaded with 0xA000_0000 | address.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk;
    logic          rstn;
    logic          cpu_en;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ahb_req;
    logic          ahb_we;
    logic [AW-1:0] ahb_addr;
    logic [DW-1:0] ahb_wdata;
    logic          ahb_gnt;
    logic          ahb_rvalid;
    logic [DW-1:0] ahb_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_wen;
    logic [DW-1:0] mem_dout;

    logic [DW-1:0] mem [0:2047];

    int tests = 0;
    int fails = 0;

    dm_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cpu_en     (cpu_en),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ahb_req    (ahb_req),
        .ahb_we     (ahb_we),
        .ahb_addr   (ahb_addr),
        .ahb_wdata  (ahb_wdata),
        .ahb_gnt    (ahb_gnt),
        .ahb_rvalid (ahb_rvalid),
        .ahb_rdata  (ahb_rdata),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_wen    (mem_wen),
        .mem_dout   (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i] <= 32'hA000_0000 | 32'(i);
        end
    end

    always @(posedge clk) begin
        if (mem_wen) begin
            mem[mem_addr] <= mem_din;
        end
        mem_dout <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // One cycle of the CPU-streaming / AHB-starvation sequence.
    task automatic stream_cyc(input string tag, input logic [AW-1:0] caddr, input logic areq,
                              input logic e_cgnt, input logic [AW-1:0] e_maddr,
                              input logic e_crv, input logic e_arv, input logic [31:0] e_data);
        cpu_addr = caddr;
        ahb_req  = areq;
        settle();
        chk({tag, "_cpu_gnt"}, 32'(cpu_gnt), 32'(e_cgnt));
        chk({tag, "_ahb_gnt"}, 32'(ahb_gnt), 32'(areq & ~e_cgnt));
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(e_maddr));
        chk({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'(e_crv));
        chk({tag, "_ahb_rvalid"}, 32'(ahb_rvalid), 32'(e_arv));
        if (e_crv) chk({tag, "_cpu_rdata"}, cpu_rdata, e_data);
        if (e_arv) chk({tag, "_ahb_rdata"}, ahb_rdata, e_data);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn      = 1'b0;
        cpu_en    = 1'b1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = '0;
        cpu_wdata = '0;
        ahb_req   = 1'b1;
        ahb_we    = 1'b1;
        ahb_addr  = '0;
        ahb_wdata = '0;

        // 1. reset: requests held in reset are not granted
        #2;
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_ahb_gnt", 32'(ahb_gnt), 32'd0);
        chk("rst_mem_wen", 32'(mem_wen), 32'd0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_ahb_rvalid", 32'(ahb_rvalid), 32'd0);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        ahb_req = 1'b0;
        ahb_we  = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        settle();
        chk("rel_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rel_ahb_gnt", 32'(ahb_gnt), 32'd0);
        chk("rel_mem_wen", 32'(mem_wen), 32'd0);
        chk("rel_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rel_ahb_rvalid", 32'(ahb_rvalid), 32'd0);
        tick();

        // 2. AHB write then read-back
        ahb_req   = 1'b1;
        ahb_we    = 1'b1;
        ahb_addr  = 11'h010;
        ahb_wdata = 32'hDEAD_BEEF;
        settle();
        chk("ahbw_gnt", 32'(ahb_gnt), 32'd1);
        chk("ahbw_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("ahbw_mem_wen", 32'(mem_wen), 32'd1);
        chk("ahbw_mem_addr", 32'(mem_addr), 32'h010);
        chk("ahbw_mem_din", mem_din, 32'hDEAD_BEEF);
        tick();
        ahb_we = 1'b0;
        settle();
        chk("ahbr_gnt", 32'(ahb_gnt), 32'd1);
        chk("ahbr_mem_wen", 32'(mem_wen), 32'd0);
        chk("ahbw_no_rvalid", 32'(ahb_rvalid), 32'd0);
        tick();
        ahb_req = 1'b0;
        settle();
        chk("ahbr_rvalid", 32'(ahb_rvalid), 32'd1);
        chk("ahbr_rdata", ahb_rdata, 32'hDEAD_BEEF);
        chk("ahbr_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        tick();
        chk("ahbr_rvalid_drop", 32'(ahb_rvalid), 32'd0);

        // 3. cpu_en gating, then CPU priority
        cpu_en   = 1'b0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 11'h7FF;
        ahb_req  = 1'b1;
        ahb_addr = 11'h005;
        settle();
        chk("en0_ahb_gnt", 32'(ahb_gnt), 32'd1);
        chk("en0_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("en0_mem_addr", 32'(mem_addr), 32'h005);
        tick();
        cpu_en = 1'b1;
        settle();
        chk("en1_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("en1_ahb_gnt", 32'(ahb_gnt), 32'd0);
        chk("en1_mem_addr", 32'(mem_addr), 32'h7FF);
        chk("en1_ahb_rvalid", 32'(ahb_rvalid), 32'd1);
        chk("en1_ahb_rdata", ahb_rdata, 32'hA000_0005);
        tick();
        cpu_req = 1'b0;
        ahb_req = 1'b0;
        settle();
        chk("en1_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("en1_cpu_rdata", cpu_rdata, 32'hA000_07FF);
        chk("en1_ahb_rvalid_drop", 32'(ahb_rvalid), 32'd0);
        tick();

        // 4. CPU streams reads, AHB wins on the 5th cycle
        cpu_req  = 1'b1;
        ahb_addr = 11'h100;
        stream_cyc("st1", 11'h000, 1'b1, 1'b1, 11'h000, 1'b0, 1'b0, 32'h0);
        stream_cyc("st2", 11'h001, 1'b1, 1'b1, 11'h001, 1'b1, 1'b0, 32'hA000_0000);
        stream_cyc("st3", 11'h002, 1'b1, 1'b1, 11'h002, 1'b1, 1'b0, 32'hA000_0001);
        stream_cyc("st4", 11'h003, 1'b1, 1'b1, 11'h003, 1'b1, 1'b0, 32'hA000_0002);
        stream_cyc("st5", 11'h004, 1'b1, 1'b0, 11'h100, 1'b1, 1'b0, 32'hA000_0003);
        stream_cyc("st6", 11'h004, 1'b0, 1'b1, 11'h004, 1'b0, 1'b1, 32'hA000_0100);
        stream_cyc("st7", 11'h005, 1'b0, 1'b1, 11'h005, 1'b1, 1'b0, 32'hA000_0004);
        cpu_req = 1'b0;
        settle();
        chk("st8_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("st8_cpu_rdata", cpu_rdata, 32'hA000_0005);
        tick();

        // 4b. withdrawing the AHB request clears the starvation count
        cpu_req  = 1'b1;
        cpu_addr = 11'h006;
        ahb_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("wd_pre_ahb_gnt", 32'(ahb_gnt), 32'd0);
            tick();
        end
        ahb_req = 1'b0;
        tick();
        ahb_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("wd_post_ahb_gnt", 32'(ahb_gnt), 32'd0);
            tick();
        end
        settle();
        chk("wd_win_ahb_gnt", 32'(ahb_gnt), 32'd1);
        chk("wd_win_cpu_gnt", 32'(cpu_gnt), 32'd0);
        tick();
        cpu_req = 1'b0;
        ahb_req = 1'b0;
        tick();
        tick();

        // 5. alternating owners return in issue order
        cpu_req  = 1'b1;
        cpu_addr = 11'h001;
        settle();
        chk("alt_cpu_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        cpu_req  = 1'b0;
        ahb_req  = 1'b1;
        ahb_addr = 11'h002;
        settle();
        chk("alt_ahb_gnt", 32'(ahb_gnt), 32'd1);
        chk("alt_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("alt_cpu_rdata", cpu_rdata, 32'hA000_0001);
        chk("alt_ahb_rvalid0", 32'(ahb_rvalid), 32'd0);
        tick();
        ahb_req = 1'b0;
        settle();
        chk("alt_ahb_rvalid", 32'(ahb_rvalid), 32'd1);
        chk("alt_ahb_rdata", ahb_rdata, 32'hA000_0002);
        chk("alt_cpu_rvalid0", 32'(cpu_rvalid), 32'd0);
        tick();

        // 5b. CPU write then AHB read of the same word on the next cycle
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 11'h020;
        cpu_wdata = 32'h1234_5678;
        settle();
        chk("xw_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("xw_mem_wen", 32'(mem_wen), 32'd1);
        chk("xw_mem_din", mem_din, 32'h1234_5678);
        tick();
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        ahb_req  = 1'b1;
        ahb_addr = 11'h020;
        settle();
        chk("xw_ahb_gnt", 32'(ahb_gnt), 32'd1);
        chk("xw_no_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        tick();
        ahb_req = 1'b0;
        settle();
        chk("xw_ahb_rvalid", 32'(ahb_rvalid), 32'd1);
        chk("xw_ahb_rdata", ahb_rdata, 32'h1234_5678);
        tick();

        // 5c. cpu_en falls with a CPU read pending
        cpu_req  = 1'b1;
        cpu_addr = 11'h003;
        settle();
        chk("enf_cpu_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        cpu_en   = 1'b0;
        cpu_addr = 11'h004;
        settle();
        chk("enf_cpu_gnt0", 32'(cpu_gnt), 32'd0);
        chk("enf_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("enf_cpu_rdata", cpu_rdata, 32'hA000_0003);
        tick();
        chk("enf_cpu_rvalid0", 32'(cpu_rvalid), 32'd0);
        cpu_en  = 1'b1;
        cpu_req = 1'b0;
        tick();

        // 6. asynchronous reset with a read in flight
        cpu_req  = 1'b1;
        cpu_addr = 11'h007;
        settle();
        chk("rr_cpu_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        cpu_req = 1'b0;
        settle();
        chk("rr_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        rstn = 1'b0;
        settle();
        chk("rr_rvalid_drop", 32'(cpu_rvalid), 32'd0);
        tick();
        rstn = 1'b1;
        settle();
        chk("rr_rel_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rr_rel_ahb_rvalid", 32'(ahb_rvalid), 32'd0);
        tick();
        chk("rr_stale_cpu_rvalid", 32'(cpu_rvalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
